// File: rtl/deconv2d_mc_if.sv
// Kernel and pixel streams of the deconvolution engine.
// The master side supplies weights and pixels; the slave side (the engine)
// returns ready.
interface deconv2d_mc_if #(
  parameter int PIXEL_BITS = 8
);
  logic                         kernel_valid;
  logic                         kernel_ready;
  logic signed [PIXEL_BITS-1:0] kernel_weight;
  logic                         pixel_valid;
  logic                         pixel_ready;
  logic signed [PIXEL_BITS-1:0] pixel;

  modport master (
    output kernel_valid, kernel_weight, pixel_valid, pixel,
    input  kernel_ready, pixel_ready
  );

  modport slave (
    input  kernel_valid, kernel_weight, pixel_valid, pixel,
    output kernel_ready, pixel_ready
  );
endinterface

// File: rtl/deconv2d_mc.sv
// Multi-channel transposed-convolution engine.
// Every input pixel is scattered over a kw x kw window of an accumulation
// buffer at the latched stride. Channels sum into one output map, which is
// read back through a registered port with optional ReLU and saturation.
module deconv2d_mc #(
  parameter int IH         = 2,
  parameter int IW         = 2,
  parameter int K          = 3,
  parameter int C          = 1,
  parameter int PIXEL_BITS = 8,
  parameter int ACC_BITS   = 32,
  parameter int OUT_BITS   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [$clog2(K+1)-1:0]         stride,
  input  logic [$clog2(K+1)-1:0]         kernel_width,
  input  logic                           relu_en,
  deconv2d_mc_if.slave                   stream,
  input  logic [$clog2(IH*K*IW*K)-1:0]   result_address,
  output logic signed [OUT_BITS-1:0]     final_output,
  output logic                           busy,
  output logic                           done,
  output logic                           cfg_error
);

  localparam int OHM    = IH * K;
  localparam int OWM    = IW * K;
  localparam int DEPTH  = OHM * OWM;
  localparam int AW     = $clog2(DEPTH);
  localparam int SW     = $clog2(K + 1);
  localparam int WDEPTH = C * K * K;
  localparam int WAW    = (WDEPTH > 1) ? $clog2(WDEPTH) : 1;
  localparam int CW     = (C > 1) ? $clog2(C) : 1;
  localparam int IHW    = (IH > 1) ? $clog2(IH) : 1;
  localparam int IWW    = (IW > 1) ? $clog2(IW) : 1;

  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD_KERNEL, WAIT_PIXEL, ACCUM, DONE
  } state_t;

  state_t state, state_next;

  // Job configuration captured on an accepted start.
  logic [SW-1:0] s_r, kw_r;
  logic          relu_r;

  // Sequencing counters.
  logic [AW-1:0]  clr_addr;
  logic [CW-1:0]  kch, pch;
  logic [SW-1:0]  ka, kb, ta, tb;
  logic [IHW-1:0] pi;
  logic [IWW-1:0] pj;

  // Storage: weight table and accumulation buffer.
  logic signed [PIXEL_BITS-1:0] w_mem   [WDEPTH];
  logic signed [ACC_BITS-1:0]   acc_mem [DEPTH];

  logic signed [PIXEL_BITS-1:0]   pix_p0;
  logic signed [2*PIXEL_BITS-1:0] prod;
  logic signed [ACC_BITS-1:0]     prod_ext;
  logic signed [ACC_BITS-1:0]     rd_val;
  logic [AW-1:0]                  acc_addr;
  logic [WAW-1:0]                 w_rd_idx, w_wr_idx;

  logic cfg_ok, k_fire, p_fire;
  logic clr_last, k_last, kb_last, ka_last, tb_last, ta_last, tap_last, pix_last;
  logic kernel_ready_c, pixel_ready_c;

  // Negative values clamp to zero when ReLU is enabled for the job.
  function automatic logic signed [ACC_BITS-1:0] relu_clamp(
    input logic signed [ACC_BITS-1:0] v,
    input logic                       en
  );
    return (en && (v < 0)) ? '0 : v;
  endfunction

  // Clip the accumulator into the signed readout range.
  function automatic logic signed [OUT_BITS-1:0] sat_out(
    input logic signed [ACC_BITS-1:0] v
  );
    logic signed [ACC_BITS-1:0] hi, lo;
    hi = {{(ACC_BITS-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
    lo = ~hi;
    if (v > hi)      sat_out = hi[OUT_BITS-1:0];
    else if (v < lo) sat_out = lo[OUT_BITS-1:0];
    else             sat_out = v[OUT_BITS-1:0];
  endfunction

  // Decode handshakes, loop terminations and buffer/weight addresses.
  always_comb begin
    cfg_ok   = (stride != '0) && (stride <= SW'(K)) &&
               (kernel_width != '0) && (kernel_width <= SW'(K));
    k_fire   = (state == LOAD_KERNEL) && stream.kernel_valid;
    p_fire   = (state == WAIT_PIXEL) && stream.pixel_valid;
    clr_last = (clr_addr == AW'(DEPTH - 1));
    kb_last  = (kb == kw_r - SW'(1));
    ka_last  = (ka == kw_r - SW'(1));
    k_last   = (kch == CW'(C - 1)) && ka_last && kb_last;
    tb_last  = (tb == kw_r - SW'(1));
    ta_last  = (ta == kw_r - SW'(1));
    tap_last = ta_last && tb_last;
    pix_last = (pch == CW'(C - 1)) && (pi == IHW'(IH - 1)) && (pj == IWW'(IW - 1));
    acc_addr = AW'((32'(pi) * 32'(s_r) + 32'(ta)) * 32'(OWM) +
                   32'(pj) * 32'(s_r) + 32'(tb));
    w_rd_idx = WAW'(32'(pch) * 32'(K * K) + 32'(ta) * 32'(K) + 32'(tb));
    w_wr_idx = WAW'(32'(kch) * 32'(K * K) + 32'(ka) * 32'(K) + 32'(kb));
    prod     = pix_p0 * w_mem[w_rd_idx];
    prod_ext = ACC_BITS'(prod);
    rd_val   = (32'(result_address) < 32'(DEPTH)) ? acc_mem[result_address] : '0;
  end

  // State register; reset aborts any job immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state and status decode.
  always_comb begin
    state_next     = state;
    kernel_ready_c = 1'b0;
    pixel_ready_c  = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    case (state)
      IDLE: begin
        if (start && cfg_ok) state_next = CLEAR;
      end
      CLEAR: begin
        busy = 1'b1;
        if (clr_last) state_next = LOAD_KERNEL;
      end
      LOAD_KERNEL: begin
        busy           = 1'b1;
        kernel_ready_c = 1'b1;
        if (k_fire && k_last) state_next = WAIT_PIXEL;
      end
      WAIT_PIXEL: begin
        busy          = 1'b1;
        pixel_ready_c = 1'b1;
        if (p_fire) state_next = ACCUM;
      end
      ACCUM: begin
        busy = 1'b1;
        if (tap_last) state_next = pix_last ? DONE : WAIT_PIXEL;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign stream.kernel_ready = kernel_ready_c;
  assign stream.pixel_ready  = pixel_ready_c;

  // Configuration latch, config error flag and all sequencing counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_r       <= '0;
      kw_r      <= '0;
      relu_r    <= 1'b0;
      cfg_error <= 1'b0;
      clr_addr  <= '0;
      kch       <= '0;
      ka        <= '0;
      kb        <= '0;
      pch       <= '0;
      pi        <= '0;
      pj        <= '0;
      ta        <= '0;
      tb        <= '0;
    end else begin
      if (state == IDLE) begin
        kch <= '0;
        ka  <= '0;
        kb  <= '0;
        pch <= '0;
        pi  <= '0;
        pj  <= '0;
        if (start) begin
          cfg_error <= !cfg_ok;
          if (cfg_ok) begin
            s_r    <= stride;
            kw_r   <= kernel_width;
            relu_r <= relu_en;
          end
        end
      end

      clr_addr <= (state == CLEAR) ? clr_addr + AW'(1) : '0;

      if (k_fire) begin
        if (kb_last) begin
          kb <= '0;
          if (ka_last) begin
            ka  <= '0;
            kch <= kch + CW'(1);
          end else begin
            ka <= ka + SW'(1);
          end
        end else begin
          kb <= kb + SW'(1);
        end
      end

      if (p_fire) begin
        ta <= '0;
        tb <= '0;
      end else if (state == ACCUM) begin
        if (tb_last) begin
          tb <= '0;
          ta <= ta + SW'(1);
        end else begin
          tb <= tb + SW'(1);
        end
      end

      if ((state == ACCUM) && tap_last) begin
        if (pj == IWW'(IW - 1)) begin
          pj <= '0;
          if (pi == IHW'(IH - 1)) begin
            pi  <= '0;
            pch <= pch + CW'(1);
          end else begin
            pi <= pi + IHW'(1);
          end
        end else begin
          pj <= pj + IWW'(1);
        end
      end
    end
  end

  // Stage p0: weight capture and pixel capture on their handshakes.
  always_ff @(posedge clk) begin
    if (k_fire) w_mem[w_wr_idx] <= stream.kernel_weight;
    if (p_fire) pix_p0 <= stream.pixel;
  end

  // Stage p1: buffer clear sweep, then one read-modify-write per tap.
  always_ff @(posedge clk) begin
    if (state == CLEAR)      acc_mem[clr_addr] <= '0;
    else if (state == ACCUM) acc_mem[acc_addr] <= acc_mem[acc_addr] + prod_ext;
  end

  // Readout register; a same-cycle write is not forwarded, so old data is seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) final_output <= '0;
    else      final_output <= sat_out(relu_clamp(rd_val, relu_r));
  end

endmodule

// File: doc/deconv2d_mc.md
# deconv2d_mc

Multi-channel, parametrised transposed-convolution (deconvolution) engine. It accepts C input feature maps of IH×IW signed pixels and a C×kw×kw signed kernel over valid/ready streams. Each pixel is scattered into an internal accumulation buffer at runtime stride, and the summed output map is exposed through a registered read port with optional ReLU and saturation. It is the next generation of the single-channel square deconv2D used in the upsampling path, adding rectangular inputs, channels, signed arithmetic, handshakes and config checking.

## Interface
- IH, 2, input map height
- IW, 2, input map width
- K, 3, maximum kernel width and maximum stride
- C, 1, input channels, accumulated into one output map
- PIXEL_BITS, 8, signed pixel and weight width
- ACC_BITS, 32, signed accumulator width
- OUT_BITS, 16, signed readout width
- Derived: OHM=IH*K, OWM=IW*K, buffer depth OHM*OWM, address width AW=$clog2(OHM*OWM)
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  begin a job; sampled in IDLE only
- stride  in  $clog2(K+1)  output step per input pixel, legal range 1..K
- kernel_width  in  $clog2(K+1)  kw, legal range 1..K
- relu_en  in  1  clamp negatives to 0 on readout
- kernel_valid / kernel_ready  in / out  1  kernel stream handshake
- kernel_weight  in  PIXEL_BITS  signed weight
- pixel_valid / pixel_ready  in / out  1  pixel stream handshake
- pixel  in  PIXEL_BITS  signed pixel
- result_address  in  AW  flat read index r*OWM+c
- final_output  out  OUT_BITS  registered readout
- busy  out  1  job in progress
- done  out  1  one-cycle completion pulse
- cfg_error  out  1  last start rejected

## Operation
- States: IDLE, CLEAR, LOAD_KERNEL, WAIT_PIXEL, ACCUM, DONE.
- IDLE to CLEAR on start with 1≤stride≤K and 1≤kernel_width≤K:
  - stride, kw and relu_en are latched.
  - cfg_error is cleared; busy goes to 1.
- Illegal start: cfg_error goes to 1, state stays IDLE, and there is no done. cfg_error holds until the next start.
- CLEAR: writes 0 to one buffer entry per cycle, addresses 0..OHM*OWM-1, then moves to LOAD_KERNEL.
- LOAD_KERNEL:
  - kernel_ready=1.
  - Weights arrive channel-major, then row, then column: C*kw*kw words.
  - Weight (ch,a,b) is stored at ch*K*K+a*K+b. Unused taps are never read.
  - After the last handshake, moves to WAIT_PIXEL.
- WAIT_PIXEL:
  - pixel_ready=1.
  - Pixels arrive channel-major, then row-major: C*IH*IW words.
  - On handshake the pixel is registered with its (ch,i,j), and the state moves to ACCUM.
- ACCUM: kw*kw cycles, one read-modify-write per cycle over taps (a,b) in row-major order.
  - buf[(i*s+a)*OWM + j*s+b] += sext(pixel*w[ch][a][b]).
  - pixel_ready=0 throughout.
  - Then goes to DONE if this was the last pixel, else back to WAIT_PIXEL.
- DONE: done=1 for one cycle, busy drops to 0, state returns to IDLE.
- Arithmetic:
  - The product is a full 2*PIXEL_BITS signed value, sign-extended to ACC_BITS.
  - Accumulation wraps modulo 2^ACC_BITS.
- Readout:
  - v = buf[result_address].
  - If relu_en is latched and v<0, v=0.
  - v then saturates to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1].
  - Reads are allowed in any state. The buffer holds the last result until the next CLEAR.
- Valid output region is ((IH-1)*s+kw) × ((IW-1)*s+kw). Entries outside it read 0 after a job.
- kernel_valid outside LOAD_KERNEL and pixel_valid outside WAIT_PIXEL are ignored, with no data consumed.
- start while busy is ignored.

## Timing
- Reset values: busy=0, done=0, kernel_ready=0, pixel_ready=0, cfg_error=0, final_output=0, state IDLE.
- Reset mid-job aborts immediately. Buffer contents after reset are undefined until the next CLEAR.
- start accepted at edge t: busy=1 from t+1. CLEAR occupies OHM*OWM cycles. kernel_ready=1 in the cycle after the last clear write.
- Each handshake completes on a rising edge with valid&ready. Kernel load takes ≥ C*kw*kw cycles.
- Per pixel: 1 handshake cycle plus kw*kw ACCUM cycles. Peak pixel throughput is 1 per (kw*kw+1) cycles.
- done is asserted in the cycle after the final ACCUM write. busy=0 from the same edge.
- Read latency is 1 cycle: final_output reflects result_address sampled at the previous edge.
- A read of an address being written in the same cycle returns the old value.

## Test plan
- Defaults, s=1, kw=2, kernel [1,2,3,4], pixels [1,2,3,4]:
  - addr 0→1, 1→4, 7→20, 13→24, 14→16, 3→0.
  - done pulses once.
- Defaults, s=2, kw=2, all weights and pixels 1: addresses 0, 3, 21 → 1; address 4 → 0.
- Instance C=2, s=1, kw=1:
  - ch0 weight 2, pixels [1,1,1,1]; ch1 weight -3, pixels [1,2,3,4].
  - addr 0→-1, addr 1→-4 (relu_en=0); addr 1→0 with relu_en=1.
- Saturation, instance OUT_BITS=8, kw=1, s=1:
  - weight 100, pixel 100 → final_output 127.
  - weight -128, pixel 127 → -128.
- Handshake and config:
  - pixel_valid held high during ACCUM consumes no pixel.
  - start with stride=0 → cfg_error=1, busy stays 0, no done.
- Reset:
  - rst low mid-ACCUM → all outputs 0 asynchronously.
  - A following legal job produces correct results.
